// File: rtl/plab5_mcore_mem_req_net_arb_pkg.sv
// Shared definitions for the per-core memory-request network arbiter.
// Latency: none (types, constants and helpers only).
// Backpressure: not applicable.
package plab5_mcore_mem_req_net_arb_pkg;

   // Domain-switch FSM encodings
   typedef enum logic {
      RUN   = 1'b0,
      SCRUB = 1'b1
   } arb_state_t;

   // Request source indices
   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   // Index of the source that did not win
   function automatic logic other_src(input logic src);
      return ~src;
   endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_net_arb_if.sv
// Split network-message channel: control part, data part and security domain tag.
// Latency: none (wires only).
// Backpressure: val/rdy handshake, transfer on val && rdy.
interface plab5_mcore_mem_req_net_arb_if #(
   parameter int p_ctrl_nbits = 50,
   parameter int p_data_nbits = 32
);
   logic                    val;
   logic                    rdy;
   logic [p_ctrl_nbits-1:0] msg_control;
   logic [p_data_nbits-1:0] msg_data;
   logic                    domain;

   modport master (output val, msg_control, msg_data, domain, input rdy);
   modport slave  (input val, msg_control, msg_data, domain, output rdy);
endinterface

// File: rtl/plab5_mcore_rr_arb2_starve.sv
// Two-input round-robin arbiter with per-source starvation counters.
// Latency: winner is combinational; pointer/counters update on the accept edge.
// Backpressure: state only advances when the caller reports an accept.
module plab5_mcore_rr_arb2_starve
   import plab5_mcore_mem_req_net_arb_pkg::*;
#(
   parameter int p_starve_limit = 8
)(
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic winner
);

   localparam int CW = $clog2(p_starve_limit + 1);
   localparam logic [CW-1:0] LIMIT = CW'(p_starve_limit);

   logic          prio_ptr;
   logic [CW-1:0] starve0;
   logic [CW-1:0] starve1;

   // Pick the winner: lone requester, then starved source (1 over 0), then pointer
   always_comb begin
      winner = prio_ptr;
      if (req0 && !req1) begin
         winner = SRC_INST;
      end else if (req1 && !req0) begin
         winner = SRC_DATA;
      end else if (req0 && req1) begin
         if (starve1 == LIMIT) begin
            winner = SRC_DATA;
         end else if (starve0 == LIMIT) begin
            winner = SRC_INST;
         end
      end
   end

   // Rotate the pointer and track consecutive losses of a requesting loser
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_ptr <= SRC_INST;
         starve0  <= '0;
         starve1  <= '0;
      end else if (accept) begin
         prio_ptr <= other_src(winner);
         if (winner == SRC_INST) begin
            starve0 <= '0;
            if (req1 && starve1 != LIMIT) begin
               starve1 <= starve1 + CW'(1);
            end
         end else begin
            starve1 <= '0;
            if (req0 && starve0 != LIMIT) begin
               starve0 <= starve0 + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/plab5_mcore_mem_req_net_arb.sv
// Arbitrates instruction/data memory requests onto one network injection port.
// Latency: 1 cycle accept-to-out_val; 2 bubbles whenever the security domain changes.
// Backpressure: one-entry buffer, refill allowed in the same cycle it drains.
module plab5_mcore_mem_req_net_arb
   import plab5_mcore_mem_req_net_arb_pkg::*;
#(
   parameter int p_ctrl_nbits   = 50,
   parameter int p_data_nbits   = 32,
   parameter int p_starve_limit = 8
)(
   input  logic clk,
   input  logic reset,
   plab5_mcore_mem_req_net_arb_if.slave  in0,
   plab5_mcore_mem_req_net_arb_if.slave  in1,
   plab5_mcore_mem_req_net_arb_if.master out,
   output logic grant_src
);

   arb_state_t              state;
   logic                    buf_full;
   logic [p_ctrl_nbits-1:0] buf_ctrl;
   logic [p_data_nbits-1:0] buf_data;
   logic                    buf_domain;
   logic                    buf_src;
   logic                    last_domain;
   logic                    pend_domain;

   logic                    winner;
   logic                    win_val;
   logic                    win_domain;
   logic [p_ctrl_nbits-1:0] win_ctrl;
   logic [p_data_nbits-1:0] win_data;
   logic                    space;
   logic                    can_accept;
   logic                    dom_mismatch;
   logic                    accept;
   logic                    go_scrub;

   plab5_mcore_rr_arb2_starve #(
      .p_starve_limit (p_starve_limit)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req0   (in0.val),
      .req1   (in1.val),
      .accept (accept),
      .winner (winner)
   );

   // Winner's message, handshake qualification and scrub trigger
   always_comb begin
      win_val    = winner ? in1.val         : in0.val;
      win_domain = winner ? in1.domain      : in0.domain;
      win_ctrl   = winner ? in1.msg_control : in0.msg_control;
      win_data   = winner ? in1.msg_data    : in0.msg_data;
      space      = !buf_full || out.rdy;
      can_accept = space && (state == RUN);
      // Any domain change must go through SCRUB first, even with an empty buffer,
      // so a mismatched winner is never accepted directly.
      dom_mismatch = (win_domain != last_domain);
      accept     = !reset && can_accept && win_val && !dom_mismatch;
      go_scrub   = !reset && can_accept && win_val && dom_mismatch;
      in0.rdy    = accept && (winner == SRC_INST);
      in1.rdy    = accept && (winner == SRC_DATA);
   end

   assign out.val         = buf_full;
   assign out.msg_control = buf_ctrl;
   assign out.msg_data    = buf_data;
   assign out.domain      = buf_domain;
   assign grant_src       = buf_src;

   // Output buffer and domain-switch FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         buf_full    <= 1'b0;
         buf_ctrl    <= '0;
         buf_data    <= '0;
         buf_domain  <= 1'b0;
         buf_src     <= SRC_INST;
         last_domain <= 1'b0;
         pend_domain <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (accept) begin
                  buf_full   <= 1'b1;
                  buf_ctrl   <= win_ctrl;
                  buf_data   <= win_data;
                  buf_domain <= win_domain;
                  buf_src    <= winner;
               end else if (go_scrub) begin
                  // Old-domain contents are wiped on entry so they are never visible
                  // while the new domain is being admitted.
                  state       <= SCRUB;
                  pend_domain <= win_domain;
                  buf_full    <= 1'b0;
                  buf_ctrl    <= '0;
                  buf_data    <= '0;
                  buf_domain  <= 1'b0;
                  buf_src     <= SRC_INST;
               end else if (buf_full && out.rdy) begin
                  buf_full <= 1'b0;
               end
            end
            SCRUB: begin
               state       <= RUN;
               last_domain <= pend_domain;
               buf_full    <= 1'b0;
               buf_ctrl    <= '0;
               buf_data    <= '0;
               buf_domain  <= 1'b0;
               buf_src     <= SRC_INST;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_arb.sv
// Directed self-checking bench for the memory-request network arbiter.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: exercised directly through out_if.rdy.
module tb_plab5_mcore_mem_req_net_arb;

   logic clk;
   logic reset;
   logic grant_src;
   int   checks;
   int   errors;

   plab5_mcore_mem_req_net_arb_if #(.p_ctrl_nbits(50), .p_data_nbits(32)) in0_if ();
   plab5_mcore_mem_req_net_arb_if #(.p_ctrl_nbits(50), .p_data_nbits(32)) in1_if ();
   plab5_mcore_mem_req_net_arb_if #(.p_ctrl_nbits(50), .p_data_nbits(32)) out_if ();

   plab5_mcore_mem_req_net_arb #(
      .p_ctrl_nbits   (50),
      .p_data_nbits   (32),
      .p_starve_limit (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in0       (in0_if),
      .in1       (in1_if),
      .out       (out_if),
      .grant_src (grant_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic v, input logic [49:0] c,
                        input logic [31:0] d, input logic dom);
      if (idx == 0) begin
         in0_if.val = v; in0_if.msg_control = c; in0_if.msg_data = d; in0_if.domain = dom;
      end else begin
         in1_if.val = v; in1_if.msg_control = c; in1_if.msg_data = d; in1_if.domain = dom;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0);
      out_if.rdy = 1'b0;

      // Reset state
      cyc();
      cyc();
      check("rst_out_val",  64'(out_if.val),         64'h0);
      check("rst_out_ctrl", 64'(out_if.msg_control), 64'h0);
      check("rst_out_data", 64'(out_if.msg_data),    64'h0);
      check("rst_out_dom",  64'(out_if.domain),      64'h0);
      check("rst_grant",    64'(grant_src),          64'h0);
      check("rst_in0_rdy",  64'(in0_if.rdy),         64'h0);
      check("rst_in1_rdy",  64'(in1_if.rdy),         64'h0);
      reset = 1'b0;

      // 1: single source, 1-cycle latency, back-to-back throughput
      drive(0, 1'b1, 50'h1234, 32'hDEADBEEF, 1'b0);
      out_if.rdy = 1'b1;
      #1;
      check("t1_in0_rdy", 64'(in0_if.rdy), 64'h1);
      check("t1_in1_rdy", 64'(in1_if.rdy), 64'h0);
      cyc();
      check("t1_out_val",  64'(out_if.val),         64'h1);
      check("t1_out_ctrl", 64'(out_if.msg_control), 64'h1234);
      check("t1_out_data", 64'(out_if.msg_data),    64'hDEADBEEF);
      check("t1_grant",    64'(grant_src),          64'h0);
      drive(0, 1'b1, 50'h5678, 32'hCAFEF00D, 1'b0);
      #1;
      check("t1_in0_rdy_full", 64'(in0_if.rdy), 64'h1);
      cyc();
      check("t1_b2b_val",  64'(out_if.val),      64'h1);
      check("t1_b2b_data", 64'(out_if.msg_data), 64'hCAFEF00D);
      drive(0, 1'b0, '0, '0, 1'b0);
      cyc();
      check("t1_drain_val", 64'(out_if.val), 64'h0);

      // 2: round robin between two valid sources in one domain
      do_reset();
      drive(0, 1'b1, 50'hA0, 32'hA0A0, 1'b0);
      drive(1, 1'b1, 50'hB1, 32'hB1B1, 1'b0);
      out_if.rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("t2_grant%0d", i), 64'(grant_src), 64'(i % 2));
         check($sformatf("t2_data%0d", i), 64'(out_if.msg_data),
               (i % 2 == 0) ? 64'hA0A0 : 64'hB1B1);
      end
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0);
      cyc();

      // 3: domain switch inserts a SCRUB bubble with zeroed outputs
      drive(0, 1'b1, 50'h11, 32'h22, 1'b0);
      cyc();
      check("t3_in0_val",   64'(out_if.val), 64'h1);
      check("t3_in0_grant", 64'(grant_src),  64'h0);
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b1, 50'h33, 32'h44, 1'b1);
      #1;
      check("t3_in1_rdy_blocked", 64'(in1_if.rdy), 64'h0);
      cyc();
      check("t3_scrub_val",   64'(out_if.val),         64'h0);
      check("t3_scrub_ctrl",  64'(out_if.msg_control), 64'h0);
      check("t3_scrub_data",  64'(out_if.msg_data),    64'h0);
      check("t3_scrub_state", 64'(dut.state),          64'h1);
      cyc();
      check("t3_bubble2_val", 64'(out_if.val),  64'h0);
      check("t3_last_domain", 64'(dut.last_domain), 64'h1);
      check("t3_in1_rdy",     64'(in1_if.rdy),  64'h1);
      cyc();
      check("t3_in1_val",   64'(out_if.val),         64'h1);
      check("t3_in1_dom",   64'(out_if.domain),      64'h1);
      check("t3_in1_grant", 64'(grant_src),          64'h1);
      check("t3_in1_ctrl",  64'(out_if.msg_control), 64'h33);
      check("t3_in1_data",  64'(out_if.msg_data),    64'h44);
      drive(1, 1'b0, '0, '0, 1'b0);
      cyc();

      // 4: backpressure holds the buffer stable, then drain and refill together
      do_reset();
      out_if.rdy = 1'b0;
      drive(0, 1'b1, 50'h55, 32'h66, 1'b0);
      drive(1, 1'b1, 50'h77, 32'h88, 1'b0);
      #1;
      check("t4_in0_rdy_empty", 64'(in0_if.rdy), 64'h1);
      cyc();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_hold_val%0d", i),  64'(out_if.val),         64'h1);
         check($sformatf("t4_hold_ctrl%0d", i), 64'(out_if.msg_control), 64'h55);
         check($sformatf("t4_hold_data%0d", i), 64'(out_if.msg_data),    64'h66);
         check($sformatf("t4_rdy0_%0d", i),     64'(in0_if.rdy),         64'h0);
         check($sformatf("t4_rdy1_%0d", i),     64'(in1_if.rdy),         64'h0);
         cyc();
      end
      out_if.rdy = 1'b1;
      #1;
      check("t4_refill_rdy1", 64'(in1_if.rdy), 64'h1);
      cyc();
      check("t4_refill_val",   64'(out_if.val),         64'h1);
      check("t4_refill_ctrl",  64'(out_if.msg_control), 64'h77);
      check("t4_refill_grant", 64'(grant_src),          64'h1);
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0);
      cyc();
      check("t4_drain_val", 64'(out_if.val), 64'h0);

      // 5: starvation override after 8 consecutive losses
      do_reset();
      force dut.u_arb.prio_ptr = 1'b0;
      drive(0, 1'b1, 50'hC0, 32'hC0, 1'b0);
      drive(1, 1'b1, 50'hC1, 32'hC1, 1'b0);
      out_if.rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check($sformatf("t5_win0_%0d", i), 64'(grant_src), 64'h0);
      end
      check("t5_starve1", 64'(dut.u_arb.starve1), 64'h8);
      cyc();
      check("t5_starved_grant", 64'(grant_src),        64'h1);
      check("t5_starved_data",  64'(out_if.msg_data),  64'hC1);
      release dut.u_arb.prio_ptr;

      // 6: reset with a full buffer, then reset during SCRUB
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0);
      out_if.rdy = 1'b0;
      #1;
      check("t6_full_before", 64'(out_if.val), 64'h1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("t6_full_rst_val",  64'(out_if.val),         64'h0);
      check("t6_full_rst_ctrl", 64'(out_if.msg_control), 64'h0);
      drive(1, 1'b1, 50'hD1, 32'hD1, 1'b1);
      cyc();
      check("t6_in_scrub", 64'(dut.state), 64'h1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("t6_rst_val",   64'(out_if.val),      64'h0);
      check("t6_rst_state", 64'(dut.state),       64'h0);
      check("t6_rst_dom",   64'(dut.last_domain), 64'h0);
      drive(0, 1'b1, 50'hE0, 32'hE0, 1'b0);
      drive(1, 1'b1, 50'hE1, 32'hE1, 1'b0);
      out_if.rdy = 1'b1;
      #1;
      check("t6_restart_rdy0", 64'(in0_if.rdy), 64'h1);
      check("t6_restart_rdy1", 64'(in1_if.rdy), 64'h0);
      cyc();
      check("t6_restart_grant", 64'(grant_src),       64'h0);
      check("t6_restart_data",  64'(out_if.msg_data), 64'hE0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
